// File: rtl/preproc_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : preproc_seq_if
//  Purpose  : Bundles the tick feed, preprocessing-bank drive, snapshot
//             handshake and status signals of preproc_seq_ctrl.
//  Modports : master - feed / bank / strategy side (drives ticks, halt,
//                      snap_ready; observes everything else)
//             slave  - the sequencer itself
//  Options  : PREPROC_SEQ_TIMEOUT_EN adds the snap_drop status line.
//  Revision : 1.0  initial release
// ============================================================================
interface preproc_seq_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
);
  logic [DATA_WIDTH-1:0] tick_data;
  logic                  tick_valid;
  logic                  tick_ready;
  logic                  halt;
  logic [DATA_WIDTH-1:0] pp_data;
  logic                  pp_enable;
  logic                  pp_rst;
  logic                  snap_valid;
  logic                  snap_ready;
  logic [5:0]            warm_mask;
  logic [CNT_WIDTH-1:0]  sample_count;
  logic                  busy;
`ifdef PREPROC_SEQ_TIMEOUT_EN
  logic                  snap_drop;
`endif

  modport master (
    output tick_data, tick_valid, halt, snap_ready,
    input  tick_ready, pp_data, pp_enable, pp_rst, snap_valid,
           warm_mask, sample_count, busy
`ifdef PREPROC_SEQ_TIMEOUT_EN
    , input snap_drop
`endif
  );

  modport slave (
    input  tick_data, tick_valid, halt, snap_ready,
    output tick_ready, pp_data, pp_enable, pp_rst, snap_valid,
           warm_mask, sample_count, busy
`ifdef PREPROC_SEQ_TIMEOUT_EN
    , output snap_drop
`endif
  );
endinterface
`default_nettype wire

// File: rtl/preproc_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : preproc_seq_ctrl
//  Purpose  : Sequencer in front of the SMA / second-moment preprocessing
//             bank. Accepts one tick at a time, pulses the bank enable for
//             one cycle, waits out the bank latency, then offers a snapshot
//             to the strategy stage. Tracks window warm-up and flushes the
//             bank on halt.
//  Ports    : clk, rst (async, active high)
//             bus (preproc_seq_if.slave):
//               tick_data/tick_valid/tick_ready - feed handshake
//               halt                             - flush request (level)
//               pp_data/pp_enable/pp_rst         - bank drive
//               snap_valid/snap_ready            - snapshot handshake
//               warm_mask, sample_count, busy    - status
//               snap_drop (optional)             - snapshot timeout pulse
//  Options  : PREPROC_SEQ_TIMEOUT_EN - adds SNAP_TIMEOUT and snap_drop; an
//             unanswered snapshot is dropped after SNAP_TIMEOUT cycles.
//  Revision : 1.0  initial release
// ============================================================================
module preproc_seq_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int PP_LATENCY   = 1,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 8
`ifdef PREPROC_SEQ_TIMEOUT_EN
  ,
  parameter int SNAP_TIMEOUT = 64
`endif
) (
  input logic          clk,
  input logic          rst,
  preproc_seq_if.slave bus
);

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_issue   = 3'd1;
  localparam logic [2:0] c_st_wait    = 3'd2;
  localparam logic [2:0] c_st_present = 3'd3;
  localparam logic [2:0] c_st_flush   = 3'd4;

  localparam logic [3:0]           c_lat_init   = 4'(PP_LATENCY - 1);
  localparam logic [3:0]           c_flush_init = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_cnt_max    = CNT_WIDTH'(200);
  localparam int                   c_windows [6] = '{5, 10, 20, 50, 100, 200};

`ifdef PREPROC_SEQ_TIMEOUT_EN
  localparam int                c_to_w    = $clog2(SNAP_TIMEOUT) + 1;
  localparam logic [c_to_w-1:0] c_to_last = c_to_w'(SNAP_TIMEOUT - 1);
`endif

  // Registered state and outputs
  logic [2:0]            r_state;
  logic [3:0]            r_lat_cnt;
  logic [3:0]            r_flush_cnt;
  logic [DATA_WIDTH-1:0] r_pp_data;
  logic                  r_pp_enable;
  logic                  r_pp_rst;
  logic                  r_snap_valid;
  logic [5:0]            r_warm_mask;
  logic [CNT_WIDTH-1:0]  r_sample_count;

  // Next-state / next-output values
  logic [2:0]            w_state_next;
  logic [3:0]            w_lat_cnt_next;
  logic [3:0]            w_flush_cnt_next;
  logic [DATA_WIDTH-1:0] w_pp_data_next;
  logic                  w_pp_enable_next;
  logic                  w_pp_rst_next;
  logic                  w_snap_valid_next;
  logic [5:0]            w_warm_mask_next;
  logic [CNT_WIDTH-1:0]  w_sample_count_next;
  logic                  w_tick_ready;
  logic                  w_accept;

`ifdef PREPROC_SEQ_TIMEOUT_EN
  logic [c_to_w-1:0]     r_to_cnt;
  logic                  r_snap_drop;
  logic [c_to_w-1:0]     w_to_cnt_next;
  logic                  w_snap_drop_next;
  logic                  w_timeout;
`endif

  assign w_tick_ready = (r_state == c_st_idle) && !bus.halt;
  assign w_accept     = w_tick_ready && bus.tick_valid;

`ifdef PREPROC_SEQ_TIMEOUT_EN
  assign w_timeout = (r_state == c_st_present) && !bus.snap_ready &&
                     (r_to_cnt == c_to_last);
`endif

  // --------------------------------------------------------------------------
  // State register (also registers every output and internal counter)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= c_st_idle;
      r_lat_cnt      <= '0;
      r_flush_cnt    <= '0;
      r_pp_data      <= '0;
      r_pp_enable    <= 1'b0;
      r_pp_rst       <= 1'b0;
      r_snap_valid   <= 1'b0;
      r_warm_mask    <= '0;
      r_sample_count <= '0;
`ifdef PREPROC_SEQ_TIMEOUT_EN
      r_to_cnt       <= '0;
      r_snap_drop    <= 1'b0;
`endif
    end else begin
      r_state        <= w_state_next;
      r_lat_cnt      <= w_lat_cnt_next;
      r_flush_cnt    <= w_flush_cnt_next;
      r_pp_data      <= w_pp_data_next;
      r_pp_enable    <= w_pp_enable_next;
      r_pp_rst       <= w_pp_rst_next;
      r_snap_valid   <= w_snap_valid_next;
      r_warm_mask    <= w_warm_mask_next;
      r_sample_count <= w_sample_count_next;
`ifdef PREPROC_SEQ_TIMEOUT_EN
      r_to_cnt       <= w_to_cnt_next;
      r_snap_drop    <= w_snap_drop_next;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. halt overrides everything, including a same-cycle
  // tick handshake and a same-cycle snapshot transfer.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    if (bus.halt) begin
      w_state_next = c_st_flush;
    end else begin
      case (r_state)
        c_st_idle:    if (bus.tick_valid) w_state_next = c_st_issue;
        c_st_issue:   w_state_next = c_st_wait;
        c_st_wait:    if (r_lat_cnt == '0) w_state_next = c_st_present;
        c_st_present: begin
          if (bus.snap_ready) w_state_next = c_st_idle;
`ifdef PREPROC_SEQ_TIMEOUT_EN
          else if (w_timeout) w_state_next = c_st_idle;
`endif
        end
        c_st_flush:   if (r_flush_cnt == '0) w_state_next = c_st_idle;
        default:      w_state_next = c_st_idle;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output logic: outputs are registered, so their next values are decoded
  // from the next state; they are then valid for the whole target state.
  // --------------------------------------------------------------------------
  always_comb begin
    w_pp_data_next    = w_accept ? bus.tick_data : r_pp_data;
    w_pp_enable_next  = (w_state_next == c_st_issue);
    w_snap_valid_next = (w_state_next == c_st_present);
    w_pp_rst_next     = (w_state_next == c_st_flush);

    w_lat_cnt_next = r_lat_cnt;
    if (r_state == c_st_issue)
      w_lat_cnt_next = c_lat_init;
    else if ((r_state == c_st_wait) && (r_lat_cnt != '0))
      w_lat_cnt_next = r_lat_cnt - 4'd1;

    // A held halt keeps reloading, so the flush ends FLUSH_CYCLES after it falls.
    w_flush_cnt_next = r_flush_cnt;
    if (bus.halt)
      w_flush_cnt_next = c_flush_init;
    else if ((r_state == c_st_flush) && (r_flush_cnt != '0))
      w_flush_cnt_next = r_flush_cnt - 4'd1;

    w_sample_count_next = r_sample_count;
    if (w_state_next == c_st_flush)
      w_sample_count_next = '0;
    else if ((r_state == c_st_issue) && (r_sample_count < c_cnt_max))
      w_sample_count_next = r_sample_count + 1'b1;

    // Warm mask trails sample_count by one cycle.
    w_warm_mask_next = '0;
    if (w_state_next != c_st_flush) begin
      for (int i = 0; i < 6; i++)
        w_warm_mask_next[i] = (int'(r_sample_count) >= c_windows[i]);
    end

`ifdef PREPROC_SEQ_TIMEOUT_EN
    // Cleared while waiting so the count starts at zero on PRESENT entry.
    w_to_cnt_next = r_to_cnt;
    if (r_state == c_st_wait)
      w_to_cnt_next = '0;
    else if ((r_state == c_st_present) && !bus.snap_ready && !w_timeout)
      w_to_cnt_next = r_to_cnt + 1'b1;
    w_snap_drop_next = w_timeout && !bus.halt;
`endif
  end

  assign bus.tick_ready   = w_tick_ready;
  assign bus.busy         = (r_state != c_st_idle);
  assign bus.pp_data      = r_pp_data;
  assign bus.pp_enable    = r_pp_enable;
  assign bus.pp_rst       = r_pp_rst;
  assign bus.snap_valid   = r_snap_valid;
  assign bus.warm_mask    = r_warm_mask;
  assign bus.sample_count = r_sample_count;
`ifdef PREPROC_SEQ_TIMEOUT_EN
  assign bus.snap_drop    = r_snap_drop;
`endif

endmodule
`default_nettype wire

// File: tb/tb_preproc_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_preproc_seq_ctrl
//  Purpose  : Self-checking bench for preproc_seq_ctrl: directed vector table,
//             hand-written corner sequences, and randomized traffic compared
//             against a transaction-timing reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_preproc_seq_ctrl;

  localparam int c_lat   = 1;
  localparam int c_flush = 2;
  localparam int c_to    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  preproc_seq_if #(.DATA_WIDTH(8), .CNT_WIDTH(8)) bus ();

  preproc_seq_ctrl #(
    .DATA_WIDTH  (8),
    .PP_LATENCY  (c_lat),
    .FLUSH_CYCLES(c_flush),
    .CNT_WIDTH   (8)
`ifdef PREPROC_SEQ_TIMEOUT_EN
    , .SNAP_TIMEOUT(c_to)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] warm_of(input int n);
    int w [6] = '{5, 10, 20, 50, 100, 200};
    logic [5:0] m = '0;
    for (int i = 0; i < 6; i++) m[i] = (n >= w[i]);
    return m;
  endfunction

  // --------------------------------------------------------------------------
  // Reference model: every transaction is timed from its acceptance cycle.
  // ISSUE is acc+1, snapshot offered from acc+2+latency until taken;
  // a halt at cycle c keeps the bank in flush through c+FLUSH_CYCLES.
  // --------------------------------------------------------------------------
  int         cyc, t_acc, flush_end, m_cnt, drop_at;
  logic       m_txn;
  logic [7:0] m_data;
  logic [5:0] m_warm;

  always @(negedge clk) begin
    logic e_en, e_sv, e_fl, e_busy, e_rdy;
    if (rst) begin
      cyc = 0; t_acc = 0; flush_end = 0; m_cnt = 0; drop_at = -1;
      m_txn = 1'b0; m_data = 8'h00; m_warm = 6'h00;
    end else begin
      e_en   = m_txn && (cyc == t_acc + 1);
      e_sv   = m_txn && (cyc >= t_acc + 2 + c_lat);
      e_fl   = (cyc < flush_end);
      e_busy = m_txn || e_fl;
      e_rdy  = !bus.halt && !e_busy;
      chk("mon_tick_ready", int'(bus.tick_ready), int'(e_rdy));
      chk("mon_pp_enable", int'(bus.pp_enable), int'(e_en));
      chk("mon_snap_valid", int'(bus.snap_valid), int'(e_sv));
      chk("mon_pp_rst", int'(bus.pp_rst), int'(e_fl));
      chk("mon_busy", int'(bus.busy), int'(e_busy));
      chk("mon_pp_data", int'(bus.pp_data), int'(m_data));
      chk("mon_sample_count", int'(bus.sample_count), m_cnt);
      chk("mon_warm_mask", int'(bus.warm_mask), int'(m_warm));
`ifdef PREPROC_SEQ_TIMEOUT_EN
      chk("mon_snap_drop", int'(bus.snap_drop), int'(cyc == drop_at));
`endif
      m_warm = bus.halt ? 6'h00 : warm_of(m_cnt);
      if (bus.halt) m_cnt = 0;
      else if (e_en && m_cnt < 200) m_cnt = m_cnt + 1;
      if (bus.halt) begin
        m_txn = 1'b0;
        flush_end = cyc + 1 + c_flush;
      end else if (e_rdy && bus.tick_valid) begin
        m_txn = 1'b1; t_acc = cyc; m_data = bus.tick_data;
      end else if (e_sv && bus.snap_ready) begin
        m_txn = 1'b0;
      end
`ifdef PREPROC_SEQ_TIMEOUT_EN
      else if (e_sv && cyc == t_acc + 2 + c_lat + c_to - 1) begin
        m_txn = 1'b0; drop_at = cyc + 1;
      end
`endif
      cyc++;
    end
  end

  // --------------------------------------------------------------------------
  // Directed vectors: one row per clock cycle
  // --------------------------------------------------------------------------
  typedef struct {
    logic       tv;
    logic [7:0] td;
    logic       sr;
    logic       h;
    logic       e_rdy;
    logic       e_en;
    logic       e_sv;
    logic       e_rst;
    logic       e_busy;
    logic [7:0] e_data;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t tbl [14];

  task automatic drive(input logic tv, input logic [7:0] td, input logic sr, input logic h);
    @(posedge clk);
    #1;
    bus.tick_valid = tv; bus.tick_data = td; bus.snap_ready = sr; bus.halt = h;
  endtask

  task automatic wait_enable(input string nm);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.pp_enable) seen = 1;
    end
    chk(nm, int'(seen), 1);
  endtask

  task automatic wait_snap(input string nm);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.snap_valid) seen = 1;
    end
    chk(nm, int'(seen), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_saved;
    //                tv    td     sr    h     rdy   en    sv    rst   busy  data   cnt
    tbl[0]  = '{1'b1, 8'h42, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h42, 8'd0};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h42, 8'd1};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h42, 8'd1};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h42, 8'd1};
    tbl[5]  = '{1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h42, 8'd1};
    tbl[6]  = '{1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h42, 8'd0};
    tbl[7]  = '{1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h42, 8'd0};
    tbl[8]  = '{1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h42, 8'd0};
    tbl[9]  = '{1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h42, 8'd0};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h42, 8'd0};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h42, 8'd0};
    tbl[12] = '{1'b1, 8'h13, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h42, 8'd0};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h13, 8'd0};

    bus.tick_valid = 1'b0; bus.tick_data = 8'h00; bus.snap_ready = 1'b0; bus.halt = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tick_ready", int'(bus.tick_ready), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_pp_enable", int'(bus.pp_enable), 0);
    chk("rst_pp_rst", int'(bus.pp_rst), 0);
    chk("rst_snap_valid", int'(bus.snap_valid), 0);
    chk("rst_pp_data", int'(bus.pp_data), 0);
    chk("rst_warm_mask", int'(bus.warm_mask), 0);
    chk("rst_sample_count", int'(bus.sample_count), 0);
    rst = 1'b0;

    // Single tick timing, then halt colliding with a tick and held 5 cycles
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].tv, tbl[i].td, tbl[i].sr, tbl[i].h);
      @(negedge clk);
      chk($sformatf("tbl%0d_tick_ready", i), int'(bus.tick_ready), int'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_pp_enable", i), int'(bus.pp_enable), int'(tbl[i].e_en));
      chk($sformatf("tbl%0d_snap_valid", i), int'(bus.snap_valid), int'(tbl[i].e_sv));
      chk($sformatf("tbl%0d_pp_rst", i), int'(bus.pp_rst), int'(tbl[i].e_rst));
      chk($sformatf("tbl%0d_busy", i), int'(bus.busy), int'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_pp_data", i), int'(bus.pp_data), int'(tbl[i].e_data));
      chk($sformatf("tbl%0d_sample_count", i), int'(bus.sample_count), int'(tbl[i].e_cnt));
    end

    // Asynchronous reset in the middle of a transaction
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_sample_count", int'(bus.sample_count), 0);
    chk("arst_pp_data", int'(bus.pp_data), 0);
    chk("arst_tick_ready", int'(bus.tick_ready), 1);
    @(posedge clk);
    #1 rst = 1'b0;

    // 201 back-to-back ticks: warm-up steps and saturation
    drive(1'b1, 8'h05, 1'b1, 1'b0);
    for (int k = 1; k <= 201; k++) begin
      bus.tick_data = 8'(k);
      wait_enable($sformatf("stream_enable%0d", k));
      @(negedge clk);
      chk($sformatf("stream_count%0d", k), int'(bus.sample_count), (k > 200) ? 200 : k);
      @(negedge clk);
      chk($sformatf("stream_warm%0d", k), int'(bus.warm_mask),
          int'(warm_of((k > 200) ? 200 : k)));
    end
    chk("sat_count", int'(bus.sample_count), 200);
    chk("sat_warm", int'(bus.warm_mask), 6'h3F);

    // Snapshot held while the strategy stage stalls
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    wait_enable("stall_enable");
    wait_snap("stall_snap");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_snap_valid", int'(bus.snap_valid), 1);
      chk("stall_tick_ready", int'(bus.tick_ready), 0);
      chk("stall_pp_enable", int'(bus.pp_enable), 0);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    chk("release_transfer", int'(bus.snap_valid), 1);
    @(negedge clk);
    chk("release_snap_valid", int'(bus.snap_valid), 0);
    chk("release_busy", int'(bus.busy), 0);

    // Halt in PRESENT after 30 ticks
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    rst = 1'b1;
    drive(1'b1, 8'h30, 1'b1, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= 30; k++) wait_enable($sformatf("h30_enable%0d", k));
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    wait_snap("h30_snap");
    chk("h30_count", int'(bus.sample_count), 30);
    chk("h30_warm", int'(bus.warm_mask), 6'b000111);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    chk("h30_snap_still", int'(bus.snap_valid), 1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    chk("h30_snap_drop", int'(bus.snap_valid), 0);
    chk("h30_pp_rst1", int'(bus.pp_rst), 1);
    chk("h30_count0", int'(bus.sample_count), 0);
    chk("h30_warm0", int'(bus.warm_mask), 0);
    @(negedge clk);
    chk("h30_pp_rst2", int'(bus.pp_rst), 1);
    @(negedge clk);
    chk("h30_pp_rst_end", int'(bus.pp_rst), 0);
    chk("h30_tick_ready", int'(bus.tick_ready), 1);

`ifdef PREPROC_SEQ_TIMEOUT_EN
    // Unanswered snapshot is dropped after the timeout
    drive(1'b1, 8'h5A, 1'b0, 1'b0);
    wait_enable("to_enable");
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    wait_snap("to_snap");
    cnt_saved = int'(bus.sample_count);
    for (int i = 0; i < c_to - 1; i++) begin
      @(negedge clk);
      chk("to_snap_hold", int'(bus.snap_valid), 1);
      chk("to_no_drop", int'(bus.snap_drop), 0);
    end
    @(negedge clk);
    chk("to_drop", int'(bus.snap_drop), 1);
    chk("to_snap_fall", int'(bus.snap_valid), 0);
    chk("to_idle", int'(bus.busy), 0);
    chk("to_count", int'(bus.sample_count), cnt_saved);
`else
    cnt_saved = 0;
`endif

    // Randomized traffic checked by the reference model
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 9) < 6,
            $urandom_range(0, 49) == 0);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
